// File: rtl/dec_pkg.sv
// Shared types and constants for the registered one-hot/thermometer decoder.
// Imported by onehot_therm_enc and seq_onehot_decoder.
package dec_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } dec_state_e;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERM  = 1'b1;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/onehot_therm_enc.sv
// Combinational select encoder: binary index -> one-hot or thermometer vector,
// plus a flag for indices beyond the number of output lines.
module onehot_therm_enc
    import dec_pkg::*;
#(
    parameter int IN_W    = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [IN_W-1:0]    sel,
    input  logic               mode,
    output logic [NUM_OUT-1:0] vec,
    output logic               range_err
);

    // Out-of-range selects produce an all-zero vector so nothing downstream strobes.
    always_comb begin
        range_err = (int'(sel) >= NUM_OUT);
        vec       = '0;
        if (!range_err) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (mode == MODE_THERM) begin
                    vec[i] = (i <= int'(sel));
                end else begin
                    vec[i] = (i == int'(sel));
                end
            end
        end
    end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered select decoder with valid/ready input and programmable hold time.
// Optional macro DEC_ERR_CNT_EN adds a saturating err_count output.
module seq_onehot_decoder
    import dec_pkg::*;
#(
    parameter int IN_W         = 3,
    parameter int NUM_OUT      = 8,
    parameter int PULSE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_sel,
    input  logic               in_mode,
    output logic [NUM_OUT-1:0] out,
    output logic               out_valid,
    output logic               err,
    output logic               busy
`ifdef DEC_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

    dec_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;

    logic [NUM_OUT-1:0] enc_vec;
    logic               enc_range_err;
    logic               accept;

    onehot_therm_enc #(
        .IN_W    (IN_W),
        .NUM_OUT (NUM_OUT)
    ) u_enc (
        .sel       (in_sel),
        .mode      (in_mode),
        .vec       (enc_vec),
        .range_err (enc_range_err)
    );

    // Ready on the final hold cycle too, so back-to-back requests leave no zero gap.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && en) begin
            case (state_q)
                IDLE:    in_ready = 1'b1;
                ACTIVE:  in_ready = (cnt_q == '0);
                default: in_ready = 1'b1;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = IDLE;
        cnt_d       = '0;
        out_d       = '0;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        if (en) begin
            if (accept) begin
                if (enc_range_err) begin
                    err_d = 1'b1;
                end else begin
                    state_d     = ACTIVE;
                    cnt_d       = CNT_W'(PULSE_CYCLES - 1);
                    out_d       = enc_vec;
                    out_valid_d = 1'b1;
                end
            end else if (state_q == ACTIVE && cnt_q != '0) begin
                state_d     = ACTIVE;
                cnt_d       = cnt_q - 1'b1;
                out_d       = out_q;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

`ifdef DEC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    // Counts in step with the err register so the count and pulse appear together.
    always_comb begin
        err_count_d = err_count_q;
        if (err_d && err_count_q != {ERR_CNT_W{1'b1}}) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Directed self-checking bench for seq_onehot_decoder: three instances cover
// the default build, a 4-cycle hold and a non-power-of-two output count.
module tb_seq_onehot_decoder;
    import dec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: IN_W=3, NUM_OUT=8, PULSE_CYCLES=1
    logic       a_en = 1'b1, a_valid = 1'b0, a_mode = 1'b0;
    logic [2:0] a_sel = '0;
    logic       a_ready, a_out_valid, a_err, a_busy;
    logic [7:0] a_out;

    // Instance B: IN_W=3, NUM_OUT=8, PULSE_CYCLES=4
    logic       b_en = 1'b1, b_valid = 1'b0, b_mode = 1'b0;
    logic [2:0] b_sel = '0;
    logic       b_ready, b_out_valid, b_err, b_busy;
    logic [7:0] b_out;

    // Instance C: IN_W=3, NUM_OUT=6, PULSE_CYCLES=1
    logic       c_en = 1'b1, c_valid = 1'b0, c_mode = 1'b0;
    logic [2:0] c_sel = '0;
    logic       c_ready, c_out_valid, c_err, c_busy;
    logic [5:0] c_out;

`ifdef DEC_ERR_CNT_EN
    logic [7:0] a_err_count, b_err_count, c_err_count;
`endif

    int assertCount = 0;
    int failCount   = 0;

    seq_onehot_decoder #(.IN_W(3), .NUM_OUT(8), .PULSE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .in_valid(a_valid), .in_ready(a_ready),
        .in_sel(a_sel), .in_mode(a_mode), .out(a_out), .out_valid(a_out_valid),
        .err(a_err), .busy(a_busy)
`ifdef DEC_ERR_CNT_EN
        , .err_count(a_err_count)
`endif
    );

    seq_onehot_decoder #(.IN_W(3), .NUM_OUT(8), .PULSE_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .in_valid(b_valid), .in_ready(b_ready),
        .in_sel(b_sel), .in_mode(b_mode), .out(b_out), .out_valid(b_out_valid),
        .err(b_err), .busy(b_busy)
`ifdef DEC_ERR_CNT_EN
        , .err_count(b_err_count)
`endif
    );

    seq_onehot_decoder #(.IN_W(3), .NUM_OUT(6), .PULSE_CYCLES(1)) dut_c (
        .clk(clk), .rst(rst), .en(c_en), .in_valid(c_valid), .in_ready(c_ready),
        .in_sel(c_sel), .in_mode(c_mode), .out(c_out), .out_valid(c_out_valid),
        .err(c_err), .busy(c_busy)
`ifdef DEC_ERR_CNT_EN
        , .err_count(c_err_count)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] expOneHot;

        // Reset with a pending request: nothing may leak through.
        a_valid = 1'b1;
        a_sel   = 3'd5;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("rst_out", 32'(a_out), 32'h0);
            checkOutput("rst_out_valid", 32'(a_out_valid), 32'h0);
            checkOutput("rst_err", 32'(a_err), 32'h0);
            checkOutput("rst_ready", 32'(a_ready), 32'h0);
        end
        rst = 1'b0;

        // One-hot sweep, back-to-back at full throughput.
        a_mode = MODE_ONEHOT;
        for (int i = 0; i < 8; i++) begin
            a_sel = 3'(i);
            #1;
            checkOutput("sweep_ready", 32'(a_ready), 32'h1);
            applyStimulus();
            expOneHot = 8'h01 << i;
            checkOutput("sweep_out", 32'(a_out), 32'(expOneHot));
            checkOutput("sweep_valid", 32'(a_out_valid), 32'h1);
        end
        checkOutput("sweep_err", 32'(a_err), 32'h0);

        // Thermometer patterns.
        a_mode = MODE_THERM;
        a_sel  = 3'd3;
        applyStimulus();
        checkOutput("therm3", 32'(a_out), 32'h0F);
        a_sel = 3'd7;
        applyStimulus();
        checkOutput("therm7", 32'(a_out), 32'hFF);
        a_sel = 3'd0;
        applyStimulus();
        checkOutput("therm0", 32'(a_out), 32'h01);
        a_valid = 1'b0;
        applyStimulus();
        checkOutput("a_idle_out", 32'(a_out), 32'h0);
        checkOutput("a_idle_valid", 32'(a_out_valid), 32'h0);
        checkOutput("a_idle_busy", 32'(a_busy), 32'h0);

        // Hold for 4 cycles with a second request waiting upstream.
        b_mode  = MODE_ONEHOT;
        b_valid = 1'b1;
        b_sel   = 3'd2;
        applyStimulus();
        b_sel = 3'd5;
        for (int k = 1; k <= 4; k++) begin
            checkOutput("hold_out", 32'(b_out), 32'h04);
            checkOutput("hold_ready", 32'(b_ready), (k == 4) ? 32'h1 : 32'h0);
            applyStimulus();
        end
        b_valid = 1'b0;
        checkOutput("nogap_out", 32'(b_out), 32'h20);
        checkOutput("nogap_valid", 32'(b_out_valid), 32'h1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("hold2_out", 32'(b_out), 32'h20);
        end
        applyStimulus();
        checkOutput("hold_end_out", 32'(b_out), 32'h0);
        checkOutput("hold_end_busy", 32'(b_busy), 32'h0);

        // Abort a hold by dropping enable on its second cycle.
        b_valid = 1'b1;
        b_sel   = 3'd1;
        applyStimulus();
        b_valid = 1'b0;
        checkOutput("abort_first", 32'(b_out), 32'h02);
        applyStimulus();
        checkOutput("abort_second", 32'(b_out), 32'h02);
        b_en = 1'b0;
        #1;
        checkOutput("abort_ready_off", 32'(b_ready), 32'h0);
        applyStimulus();
        checkOutput("abort_out", 32'(b_out), 32'h0);
        checkOutput("abort_valid", 32'(b_out_valid), 32'h0);
        checkOutput("abort_busy", 32'(b_busy), 32'h0);
        b_en = 1'b1;
        #1;
        checkOutput("reen_ready", 32'(b_ready), 32'h1);
        b_valid = 1'b1;
        b_sel   = 3'd6;
        applyStimulus();
        b_valid = 1'b0;
        checkOutput("reen_out", 32'(b_out), 32'h40);

        // Out-of-range selects on the 6-output instance.
        c_mode  = MODE_ONEHOT;
        c_valid = 1'b1;
        c_sel   = 3'd6;
        applyStimulus();
        checkOutput("range6_err", 32'(c_err), 32'h1);
        checkOutput("range6_out", 32'(c_out), 32'h0);
        checkOutput("range6_valid", 32'(c_out_valid), 32'h0);
        checkOutput("range6_busy", 32'(c_busy), 32'h0);
        c_sel = 3'd7;
        applyStimulus();
        checkOutput("range7_err", 32'(c_err), 32'h1);
        c_valid = 1'b0;
        applyStimulus();
        checkOutput("range_err_clear", 32'(c_err), 32'h0);
`ifdef DEC_ERR_CNT_EN
        checkOutput("err_count_two", 32'(c_err_count), 32'd2);
`endif
        c_mode  = MODE_THERM;
        c_valid = 1'b1;
        c_sel   = 3'd5;
        applyStimulus();
        checkOutput("c_therm5", 32'(c_out), 32'h3F);
        checkOutput("c_therm5_err", 32'(c_err), 32'h0);

        // Disabled block must not flag an error.
        c_en  = 1'b0;
        c_sel = 3'd7;
        applyStimulus();
        checkOutput("dis_err", 32'(c_err), 32'h0);
        checkOutput("dis_out", 32'(c_out), 32'h0);

        c_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            applyStimulus();
        end
        c_valid = 1'b0;
        checkOutput("burst_err", 32'(c_err), 32'h1);
`ifdef DEC_ERR_CNT_EN
        checkOutput("err_count_sat", 32'(c_err_count), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/seq_onehot_decoder.md
Name: seq_onehot_decoder

Overview:
Parametrised, registered successor to the team's combinational 3-to-8 decoder. Accepts a binary select over a valid/ready handshake and drives a registered one-hot or thermometer output vector for a programmable number of cycles. It flags out-of-range selects and returns the output to zero afterwards. Used as the strobe/select generator in front of banked register files and multi-channel enables.

Parameters:
IN_W, 3, width of binary select input
NUM_OUT, 8, number of output lines; legal range 2..2**IN_W (non-power-of-two allowed)
PULSE_CYCLES, 1, cycles each decoded output is held asserted; must be >=1
CNT_W, $clog2(PULSE_CYCLES+1), localparam, hold-counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  block enable; 0 forces the output to zero and blocks acceptance
in_valid  input  1  select request valid
in_ready  output  1  block can accept a request this cycle (combinational)
in_sel  input  IN_W  binary select index
in_mode  input  1  0 = one-hot, 1 = thermometer; sampled with in_sel
out  output  NUM_OUT  registered decoded vector
out_valid  output  1  high while out carries a decoded value
err  output  1  one-cycle pulse: accepted in_sel >= NUM_OUT
busy  output  1  state == ACTIVE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, out=0, out_valid=0, err=0, counter=0. rst has priority over every other input.
- States:
  - IDLE: output zero.
  - ACTIVE: output held; counter counts down.
- in_ready = en && (state==IDLE || (state==ACTIVE && cnt==0)). This allows back-to-back acceptance on the final hold cycle.
- Accept = in_valid && in_ready. Latency is 1 cycle from accept to out/out_valid.
- Accept with in_sel < NUM_OUT: next cycle state=ACTIVE, out_valid=1, cnt=PULSE_CYCLES-1.
  - one-hot: out[i] = (i==in_sel).
  - thermometer: out[i] = (i<=in_sel). in_sel=0 gives only bit 0 set.
- Accept with in_sel >= NUM_OUT (only reachable when NUM_OUT < 2**IN_W): next cycle err=1 for exactly one cycle, out=0, out_valid=0, state=IDLE.
- ACTIVE with cnt>0 and en=1: cnt decrements by 1; out held.
- ACTIVE with cnt==0:
  - No accept: next cycle out=0, out_valid=0, state=IDLE.
  - Accept: next cycle loads the new decode (or err path) with no zero gap.
- PULSE_CYCLES=1: every accepted request yields exactly one out_valid cycle. Continuous in_valid gives 100% throughput.
- en=0 in any state: in_ready=0. Next cycle out=0, out_valid=0, cnt=0, state=IDLE; an in-progress hold is aborted, not resumed. err is not generated while en=0.
- in_valid while not ready: request ignored. No internal queueing; the upstream holds it.
- out is never X after reset. Any unused or invalid state decodes to IDLE.

Optional Feature:
DEC_ERR_CNT_EN
- Defined: adds output err_count [7:0], a saturating count of err pulses. It holds at 255 once reached, is cleared only by rst, and increments in the same cycle err is asserted.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Shared package dec_pkg: state enum (IDLE, ACTIVE), mode constants MODE_ONEHOT=1'b0 and MODE_THERM=1'b1, ERR_CNT_W=8.
- Sub-module onehot_therm_enc: purely combinational (sel, mode, range check) -> vector and range-error flag, parametrised by IN_W/NUM_OUT. Instantiated once, in front of the output register.

Test Plan:
- Reset/idle: rst high 3 cycles with in_valid=1, in_sel=5 -> out=0, out_valid=0, err=0, in_ready=0 during reset.
- One-hot sweep (IN_W=3, NUM_OUT=8, PULSE=1, en=1): in_sel 0..7 back-to-back -> out 8'h01,02,04,...,80 on consecutive cycles, each 1 cycle after accept, in_ready constant 1.
- Thermometer: in_mode=1, in_sel=3 -> out=8'h0F next cycle; in_sel=7 -> 8'hFF; in_sel=0 -> 8'h01.
- Hold/backpressure (PULSE=4): accept in_sel=2 -> out=8'h04 for exactly 4 cycles; in_ready=0 for the first 3 and 1 on the 4th. Second request accepted on the 4th cycle -> new value with no zero gap.
- Range error (IN_W=3, NUM_OUT=6): in_sel=6, then 7 -> err one cycle each, out stays 0; with DEC_ERR_CNT_EN, err_count=2. Force 300 errors -> err_count=255.
- Abort: PULSE=4, accept in_sel=1, drop en on 2nd hold cycle -> out=0 and out_valid=0 next cycle, busy=0. Re-raise en -> in_ready=1 and accepts normally.
